// File: rtl/hazard_pkg.sv
// Shared types and defaults for the issue-stage hazard scoreboard.
// The in-flight entry record is shared by the destination pipe and the compare logic.
package hazard_pkg;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_CNT_W  = 16;

    typedef struct packed {
        logic                      valid;
        logic [DEFAULT_ADDR_W-1:0] rd;
        logic                      reg_w;
    } entry_t;

    localparam entry_t BUBBLE = entry_t'('0);

endpackage

// File: rtl/dest_pipe.sv
// Shift register of in-flight destination entries, EX at index 0 and WB at the top.
// Every entry is visible so the scoreboard can compare against all stages at once.
module dest_pipe
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  entry_t                   in_entry,
    output entry_t [NUM_STAGES-1:0]  pipe
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                pipe[i] <= BUBBLE;
            end
        end else begin
            // NOTE: non-blocking so each stage takes its neighbour's pre-edge value, not the freshly shifted one.
            pipe[0] <= in_entry;
            for (int i = 1; i < NUM_STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW interlock for the 5-stage R-type CPU: stalls ID while any source has a pending
// write in EX..WB, injects bubbles, and drives the register-file write port from WB.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs_addr,
    input  logic [ADDR_W-1:0] id_rt_addr,
    input  logic [ADDR_W-1:0] id_rd_addr,
    input  logic              id_reg_w,
    output logic              id_ready,
    output logic              stall,
    output logic              ex_valid,
    output logic [ADDR_W-1:0] ex_rd_addr,
    output logic              ex_reg_w,
    output logic [ADDR_W-1:0] wb_rd_addr,
    output logic              wb_reg_w,
    output logic [CNT_W-1:0]  issue_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    entry_t [NUM_STAGES-1:0] pipe;
    entry_t                  in_entry;
    logic                    hazard;
    logic                    issue;

    // The WB entry is included: the RF writes at the end of WB, so ID would read the stale value.
    always_comb begin
        // NOTE: default first so the search loop cannot infer a latch.
        hazard = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (pipe[i].valid && pipe[i].reg_w &&
                (pipe[i].rd == id_rs_addr || pipe[i].rd == id_rt_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    assign issue    = id_valid && !hazard;
    assign stall    = id_valid && hazard;
    assign id_ready = !hazard;

    // Masking reg_w for $0 keeps it from ever matching and from ever reaching the RF port.
    always_comb begin
        in_entry = BUBBLE;
        if (issue) begin
            in_entry.valid = 1'b1;
            in_entry.rd    = id_rd_addr;
            in_entry.reg_w = id_reg_w && (id_rd_addr != '0);
        end
    end

    dest_pipe #(
        .NUM_STAGES (NUM_STAGES)
    ) u_dest_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_entry (in_entry),
        .pipe     (pipe)
    );

    assign ex_valid   = pipe[0].valid;
    assign ex_rd_addr = pipe[0].rd;
    assign ex_reg_w   = pipe[0].reg_w;
    assign wb_rd_addr = pipe[NUM_STAGES-1].rd;
    assign wb_reg_w   = pipe[NUM_STAGES-1].reg_w;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (issue && issue_cnt != '1) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector tables and sequences plus
// random traffic, all compared against an in-flight history model of the issue rules.
module tb_hazard_scoreboard;

    localparam int N = 3;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs_addr, id_rt_addr, id_rd_addr;
    logic       id_reg_w;

    logic        id_ready, stall, ex_valid, ex_reg_w, wb_reg_w;
    logic [4:0]  ex_rd_addr, wb_rd_addr;
    logic [15:0] issue_cnt, stall_cnt;

    logic        s4_id_ready, s4_stall, s4_ex_valid, s4_ex_reg_w, s4_wb_reg_w;
    logic [4:0]  s4_ex_rd_addr, s4_wb_rd_addr;
    logic [3:0]  s4_issue_cnt, s4_stall_cnt;

    hazard_scoreboard #(.NUM_STAGES(N), .ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_reg_w(id_reg_w), .id_ready(id_ready), .stall(stall),
        .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_reg_w(ex_reg_w),
        .wb_rd_addr(wb_rd_addr), .wb_reg_w(wb_reg_w),
        .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.NUM_STAGES(N), .ADDR_W(5), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_reg_w(id_reg_w), .id_ready(s4_id_ready), .stall(s4_stall),
        .ex_valid(s4_ex_valid), .ex_rd_addr(s4_ex_rd_addr), .ex_reg_w(s4_ex_reg_w),
        .wb_rd_addr(s4_wb_rd_addr), .wb_reg_w(s4_wb_reg_w),
        .issue_cnt(s4_issue_cnt), .stall_cnt(s4_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d required %0d", name, $time, act, exp);
        end
    endtask

    // Model: the list of what was presented to EX on each of the last N cycles.
    typedef struct {
        bit valid;
        int rd;
        bit reg_w;
    } slot_t;

    slot_t m_hist[$];
    int    m_issued;
    int    m_stalled;

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 0; s.rd = 0; s.reg_w = 0;
        return s;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < N; i++) m_hist.push_back(empty_slot());
        m_issued  = 0;
        m_stalled = 0;
    endtask

    function automatic bit model_hazard(int rs, int rt);
        foreach (m_hist[i])
            if (m_hist[i].valid && m_hist[i].reg_w && (m_hist[i].rd == rs || m_hist[i].rd == rt))
                return 1;
        return 0;
    endfunction

    function automatic int sat(int v, int max);
        return (v > max) ? max : v;
    endfunction

    // Outputs sampled mid-cycle by the most recent step.
    bit s_stall, s_ready, s_exv, s_exw, s_wbw;
    int s_exrd, s_wbrd;

    task automatic step(input bit r, input bit v, input int rs, input int rt, input int rd, input bit w);
        bit    h;
        slot_t e;
        rst_n      = r;
        id_valid   = v;
        id_rs_addr = 5'(rs);
        id_rt_addr = 5'(rt);
        id_rd_addr = 5'(rd);
        id_reg_w   = w;
        #4;
        h = model_hazard(rs, rt);
        check("stall",      {31'd0, stall},    {31'd0, v && h});
        check("id_ready",   {31'd0, id_ready}, {31'd0, !h});
        check("ex_valid",   {31'd0, ex_valid}, {31'd0, m_hist[0].valid});
        check("ex_rd_addr", {27'd0, ex_rd_addr}, m_hist[0].rd);
        check("ex_reg_w",   {31'd0, ex_reg_w}, {31'd0, m_hist[0].reg_w});
        check("wb_rd_addr", {27'd0, wb_rd_addr}, m_hist[N-1].rd);
        check("wb_reg_w",   {31'd0, wb_reg_w}, {31'd0, m_hist[N-1].reg_w});
        check("issue_cnt",  {16'd0, issue_cnt}, sat(m_issued, 65535));
        check("stall_cnt",  {16'd0, stall_cnt}, sat(m_stalled, 65535));
        check("sat_issue_cnt", {28'd0, s4_issue_cnt}, sat(m_issued, 15));
        check("sat_stall_cnt", {28'd0, s4_stall_cnt}, sat(m_stalled, 15));
        check("sat_port_bundle",
              {17'd0, s4_id_ready, s4_stall, s4_ex_valid, s4_ex_reg_w, s4_wb_reg_w, s4_ex_rd_addr, s4_wb_rd_addr},
              {17'd0, !h, v && h, m_hist[0].valid, m_hist[0].reg_w, m_hist[N-1].reg_w,
               5'(m_hist[0].rd), 5'(m_hist[N-1].rd)});
        s_stall = stall; s_ready = id_ready; s_exv = ex_valid; s_exw = ex_reg_w;
        s_wbw = wb_reg_w; s_exrd = int'(ex_rd_addr); s_wbrd = int'(wb_rd_addr);
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            e = empty_slot();
            if (v && !h) begin
                e.valid = 1; e.rd = rd; e.reg_w = w && (rd != 0);
                m_issued++;
            end
            if (v && h) m_stalled++;
            m_hist.push_front(e);
            void'(m_hist.pop_back());
        end
        #1;
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0);
    endtask

    // Directed table: a back-to-back dependent pair starting from an empty pipe.
    typedef struct {
        bit v; int rs; int rt; int rd; bit w;
        bit e_stall; bit e_exv; int e_exrd; bit e_wbw; int e_wbrd;
    } vec_t;

    vec_t pair_tbl[6];

    task automatic run_distance(input int gap, input int exp_stalls);
        int n;
        do_reset();
        step(1, 1, 10, 11, 6, 1);
        for (int k = 0; k < gap; k++) step(1, 1, 30, 31, 20 + k, 1);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            step(1, 1, 6, 1, 8, 1);
            if (!s_stall) break;
            n++;
        end
        check($sformatf("distance_gap%0d_stalls", gap), n, exp_stalls);
    endtask

    initial begin
        pair_tbl[0] = '{1, 2, 3, 1, 1,  0, 0, 0, 0, 0};
        pair_tbl[1] = '{1, 1, 1, 4, 1,  1, 1, 1, 0, 0};
        pair_tbl[2] = '{1, 1, 1, 4, 1,  1, 0, 0, 0, 0};
        pair_tbl[3] = '{1, 1, 1, 4, 1,  1, 0, 0, 1, 1};
        pair_tbl[4] = '{1, 1, 1, 4, 1,  0, 0, 0, 0, 0};
        pair_tbl[5] = '{0, 0, 0, 0, 0,  0, 1, 4, 0, 0};

        // Reset held two cycles with id_valid high; the first edge leaves nothing to compare.
        rst_n = 0; id_valid = 1; id_rs_addr = 5'd1; id_rt_addr = 5'd2; id_rd_addr = 5'd3; id_reg_w = 1;
        @(posedge clk);
        #1;
        model_reset();
        step(0, 1, 1, 2, 3, 1);
        check("reset_stall",     {31'd0, stall},    0);
        check("reset_id_ready",  {31'd0, id_ready}, 1);
        check("reset_ex_valid",  {31'd0, ex_valid}, 0);
        check("reset_ex_reg_w",  {31'd0, ex_reg_w}, 0);
        check("reset_wb_reg_w",  {31'd0, wb_reg_w}, 0);
        check("reset_addrs",     {22'd0, ex_rd_addr, wb_rd_addr}, 0);
        check("reset_counters",  {issue_cnt, stall_cnt}, 0);

        for (int i = 0; i < 6; i++) begin
            step(1, pair_tbl[i].v, pair_tbl[i].rs, pair_tbl[i].rt, pair_tbl[i].rd, pair_tbl[i].w);
            check($sformatf("pair[%0d].stall", i),    {31'd0, s_stall}, {31'd0, pair_tbl[i].e_stall});
            check($sformatf("pair[%0d].ex_valid", i), {31'd0, s_exv},   {31'd0, pair_tbl[i].e_exv});
            check($sformatf("pair[%0d].ex_rd", i),    s_exrd,           pair_tbl[i].e_exrd);
            check($sformatf("pair[%0d].wb_reg_w", i), {31'd0, s_wbw},   {31'd0, pair_tbl[i].e_wbw});
            check($sformatf("pair[%0d].wb_rd", i),    s_wbrd,           pair_tbl[i].e_wbrd);
        end
        check("pair_issue_cnt", {16'd0, issue_cnt}, 2);
        check("pair_stall_cnt", {16'd0, stall_cnt}, 3);

        // Writes to $0 never interlock and never reach the RF port.
        do_reset();
        step(1, 1, 2, 3, 0, 1);
        step(1, 1, 0, 0, 9, 1);
        check("r0_no_stall", {31'd0, s_stall}, 0);
        check("r0_wb_off_c1", {31'd0, s_wbw}, 0);
        idle();
        check("r0_wb_off_c2", {31'd0, s_wbw}, 0);
        idle();
        check("r0_wb_off_c3", {31'd0, s_wbw}, 0);

        run_distance(0, 3);
        run_distance(1, 2);
        run_distance(3, 0);

        // id_valid dropping mid-stall clears stall at once while bubbles keep moving.
        do_reset();
        step(1, 1, 2, 3, 7, 1);
        step(1, 1, 7, 0, 8, 1);
        check("drop_pre_stall", {31'd0, s_stall}, 1);
        step(1, 0, 7, 0, 8, 1);
        check("drop_stall_clear", {31'd0, s_stall}, 0);
        check("drop_ready_low", {31'd0, s_ready}, 0);

        // Reset one cycle after issuing a write to $5 discards it.
        do_reset();
        step(1, 1, 1, 2, 5, 1);
        do_reset();
        step(1, 1, 5, 5, 3, 1);
        check("midreset_read5_issues", {31'd0, s_stall}, 0);
        for (int c = 0; c < 4; c++) begin
            idle();
            check("midreset_no_wb5", {31'd0, s_wbw && s_wbrd == 5}, 0);
        end

        // Saturation: a self-dependent chain racks up 21 stall cycles.
        do_reset();
        for (int c = 0; c < 28; c++) step(1, 1, 1, 1, 1, 1);
        check("sat_stall_hold15", {28'd0, s4_stall_cnt}, 15);
        check("wide_stall_21",    {16'd0, stall_cnt}, 21);
        check("sat_issue_7",      {28'd0, s4_issue_cnt}, 7);

        // Random traffic over a small register set to make hazards frequent.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Issue-stage interlock and write-port sequencer for the 5-stage R-type pipeline CPU. It tracks the destination register of every instruction in flight between ID and WB. It stalls the ID-stage instruction while any source register has a pending write, and injects a bubble in its place. It also supplies the WB-stage write address and enable that drive the Register File write port. The block removes RAW hazards without a forwarding network.

## Interface
- NUM_STAGES, 3, in-flight stages tracked after ID (EX, MEM, WB); minimum 1
- ADDR_W, 5, register address width
- CNT_W, 16, width of the statistics counters
- clk  in  1  rising-edge clock shared with the whole CPU
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- id_valid  in  1  ID stage holds a decoded instruction
- id_rs_addr  in  ADDR_W  source register 1 of the ID instruction
- id_rt_addr  in  ADDR_W  source register 2 of the ID instruction
- id_rd_addr  in  ADDR_W  destination register of the ID instruction
- id_reg_w  in  1  ID instruction writes the register file
- id_ready  out  1  ID instruction issues this cycle; when low, hold IF/ID
- stall  out  1  id_valid && hazard
- ex_valid  out  1  EX slot holds a real instruction (0 = bubble)
- ex_rd_addr  out  ADDR_W  destination of the EX slot
- ex_reg_w  out  1  write enable of the EX slot
- wb_rd_addr  out  ADDR_W  Register File Rd_addr
- wb_reg_w  out  1  Register File Reg_w
- issue_cnt  out  CNT_W  instructions issued, saturating
- stall_cnt  out  CNT_W  stall cycles, saturating

## Operation
- State: entry array pipe[0..NUM_STAGES-1], each entry {valid, rd, reg_w}. pipe[0] = EX and pipe[NUM_STAGES-1] = WB.
- hazard: some i has pipe[i].valid && pipe[i].reg_w && (pipe[i].rd == id_rs_addr || pipe[i].rd == id_rt_addr). This is combinational and includes the WB entry, because the RF writes on the clock edge and ID reads the old value in the same cycle.
- Register 0 never creates a hazard. An entry's reg_w is stored as id_reg_w && (id_rd_addr != 0), so wb_reg_w is never asserted for register 0.
- issue = id_valid && !hazard. id_ready = !hazard, and is high when id_valid = 0.
- Each clock:
  - pipe[i] <= pipe[i-1] for every i ≥ 1.
  - On issue, pipe[0] <= {1, id_rd_addr, masked reg_w}; otherwise pipe[0] <= bubble {0, 0, 0}.
- The pipeline never holds downstream stages. Only IF/ID is frozen.
- An instruction with id_reg_w = 0 occupies a slot as valid but never causes a hazard.
- Counters:
  - issue_cnt += 1 on issue.
  - stall_cnt += 1 when stall is high.
  - Both hold at all-ones (saturate, never wrap).

## Timing
- Reset (rst_n low at a rising edge): all pipe entries become {0, 0, 0} and both counters clear. After that edge:
  - stall = 0, id_ready = 1
  - ex_valid = ex_reg_w = wb_reg_w = 0
  - ex_rd_addr = wb_rd_addr = 0
- Reset asserted mid-operation drops all in-flight entries. No RF write occurs after the reset edge.
- Issue-to-EX latency: 1 cycle. Issue-to-WB-write: NUM_STAGES cycles. The RF write happens at the end of the WB cycle.
- A back-to-back dependent pair stalls exactly NUM_STAGES cycles (3 by default). With a gap of k independent instructions between the pair, it stalls max(0, NUM_STAGES − k) cycles.
- Simultaneous hazards on rs and rt, or matches in several stages, produce the same single stall; the youngest match governs release.
- id_valid dropping during a stall clears stall in that same cycle. Bubbles still advance.

## Structure
- Package hazard_pkg holds:
  - ADDR_W and CNT_W defaults
  - the entry typedef {valid, rd, reg_w}
  - the BUBBLE constant
- One sub-module, dest_pipe: a NUM_STAGES-deep entry shift register with synchronous reset. It exposes all entries for comparison.
- The compare logic, issue logic and counters stay in hazard_scoreboard.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with id_valid = 1 → all outputs 0 except id_ready = 1; counters 0.
- Dependent pair: issue add $1←$2,$3, then add $4←$1,$1 → stall high for exactly 3 cycles; second instruction issues on cycle 4; wb_reg_w = 1 with wb_rd_addr = 1 on cycle 3; stall_cnt = 3, issue_cnt = 2.
- Register 0: add $0←…, then an instruction reading $0 → no stall; wb_reg_w stays 0 for the first instruction.
- Distance: dependent instructions separated by 1 and by 3 independent ones → 2 stall cycles and 0 stall cycles respectively.
- Reset mid-flight: issue write to $5, assert rst_n = 0 one cycle later → wb_reg_w never pulses for $5; an instruction reading $5 issues immediately after reset.
- Saturation: CNT_W = 4, 20 consecutive stall cycles → stall_cnt holds at 15.
